// File: rtl/product_accumulator.sv
// Sums groups of LEN sign-extended products and presents the result on a held valid/ready port.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp every addition instead of wrapping.
module product_accumulator #(
    parameter int N     = 5,
    parameter int LEN   = 4,
    parameter int ACC_W = 2 * N + $clog2(LEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*N-1:0]           in_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic [$clog2(LEN):0]     out_count
);

    localparam int PW = 2 * N;
    localparam int CW = $clog2(LEN) + 1;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(LEN);

    if (LEN < 2) begin : g_len_check
        $error("product_accumulator: LEN must be at least 2");
    end
    if (ACC_W < PW) begin : g_width_check
        $error("product_accumulator: ACC_W must be at least 2*N");
    end

    logic              state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;

    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  sum_raw;
    logic [ACC_W-1:0]  sum_next;

    assign addend  = ACC_W'($signed(in_product));
    assign sum_raw = acc_q + addend;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    logic overflow;

    // Overflow only when both operands share a sign the result does not.
    assign overflow = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        sum_next = sum_raw;
        if (overflow) begin
            sum_next = acc_q[ACC_W-1] ? SUM_MIN : SUM_MAX;
        end
    end
`else
    assign sum_next = sum_raw;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;

        if (clear) begin
            // out_sum is left as-is: it is only meaningful while out_valid is high.
            state_d     = ST_ACCUM;
            acc_d       = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (count_q == LAST_IDX) begin
                            out_sum_d   = sum_next;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            count_d     = FULL_CNT;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d   = sum_next;
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        count_d     = '0;
                        state_d     = ST_ACCUM;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default-width instance plus an ACC_W=10 instance
// sharing the same stimulus for the wrap/saturation case.
module tb_product_accumulator;

    localparam int N     = 5;
    localparam int LEN   = 4;
    localparam int ACC_W = 12;
    localparam int SAT_W = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic               in_valid;
    logic [2*N-1:0]     in_product;
    logic               out_ready;

    logic               in_ready;
    logic               out_valid;
    logic [ACC_W-1:0]   out_sum;
    logic [2:0]         out_count;

    logic               s_in_ready;
    logic               s_out_valid;
    logic [SAT_W-1:0]   s_out_sum;
    logic [2:0]         s_out_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N(N), .LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count)
    );

    product_accumulator #(.N(N), .LEN(LEN), .ACC_W(SAT_W)) dut_narrow (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_product (in_product),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_sum    (s_out_sum),
        .out_count  (s_out_count)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one product for one edge, then drop in_valid.
    task automatic send(input int p);
        in_valid   = 1'b1;
        in_product = (2 * N)'(p);
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_hold(input string tag, input int sum);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_sum"}, $signed(out_sum), sum);
        chk({tag, "_count"}, 32'(out_count), 4);
        chk({tag, "_ready"}, 32'(in_ready), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b0;

        // Reset values
        #23;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_sum", $signed(out_sum), 0);
        chk("rst_count", 32'(out_count), 0);
        rst_n = 1'b1;
        tick();

        // Basic frame: 6 - 15 + 100 - 1 = 90
        send(6);
        chk("basic_cnt1", 32'(out_count), 1);
        send(-15);
        chk("basic_cnt2", 32'(out_count), 2);
        send(100);
        chk("basic_cnt3", 32'(out_count), 3);
        chk("basic_novalid", 32'(out_valid), 0);
        send(-1);
        chk_hold("basic", 90);

        // Backpressure: products offered in HOLD must not be taken
        in_valid   = 1'b1;
        in_product = (2 * N)'(33);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_hold("bp", 90);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_ready", 32'(in_ready), 1);
        chk("bp_release_count", 32'(out_count), 0);
        chk("bp_sum_kept", $signed(out_sum), 90);

        // Bubbles and extremes: 4 * -512 = -2048
        send(-512);
        repeat (3) tick();
        chk("bub_cnt1", 32'(out_count), 1);
        send(-512);
        tick();
        chk("bub_cnt2", 32'(out_count), 2);
        send(-512);
        chk("bub_cnt3", 32'(out_count), 3);
        send(-512);
        chk_hold("bub", -2048);
        drain();

        // Clear mid-frame drops the product offered with it
        send(7);
        send(9);
        chk("clr_pre_count", 32'(out_count), 2);
        clear = 1'b1;
        send(50);
        clear = 1'b0;
        chk("clr_count", 32'(out_count), 0);
        chk("clr_valid", 32'(out_valid), 0);
        send(1);
        send(2);
        send(3);
        send(4);
        chk_hold("clr_frame", 10);

        // Clear in HOLD beats a simultaneous output transfer
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("clr_hold_valid", 32'(out_valid), 0);
        chk("clr_hold_count", 32'(out_count), 0);
        chk("clr_hold_ready", 32'(in_ready), 1);

        // Asynchronous reset between edges, mid-frame
        send(1);
        send(1);
        chk("arst_pre_count", 32'(out_count), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(out_count), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_ready", 32'(in_ready), 1);
        #2;
        rst_n = 1'b1;
        tick();
        send(1);
        send(1);
        send(1);
        send(1);
        chk_hold("arst_frame", 4);
        drain();

        // Four products of 511: 2044 fits in 12 bits; the 10-bit instance wraps or clamps
        send(511);
        send(511);
        send(511);
        send(511);
        chk_hold("big", 2044);
        chk("narrow_valid", 32'(s_out_valid), 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        chk("narrow_sum", $signed(s_out_sum), 511);
`else
        chk("narrow_sum", $signed(s_out_sum), -4);
`endif
        drain();
        chk("final_valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
